// File: rtl/cache_fill_ctrl.sv
// Fill/write-through sequencer for a fully-associative byte cache in front of a 6502 core.
// Define CACHE_CWF_EN to fetch the critical word first on a fill (burst wraps at the block end).
module cache_fill_ctrl #(
    parameter int unsigned NUM_LINES    = 4,
    parameter int unsigned TAG_WIDTH    = 13,
    parameter int unsigned BLOCK_SIZE   = 8,
    localparam int unsigned OFFSET_WIDTH = $clog2(BLOCK_SIZE),
    localparam int unsigned ADDR_WIDTH   = TAG_WIDTH + OFFSET_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic                    cpu_rd,
    input  logic                    cpu_wr,
    input  logic [7:0]              cpu_wdata,
    output logic                    cpu_rdy,
    output logic [7:0]              cpu_rdata,
    input  logic [NUM_LINES-1:0]    line_hit,
    input  logic [7:0]              line_rdata,
    output logic                    cache_wr,
    output logic [NUM_LINES-1:0]    fill_line_en,
    output logic                    fill_tag_en,
    output logic                    fill_en,
    output logic [OFFSET_WIDTH-1:0] fill_off,
    output logic [7:0]              fill_data,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [7:0]              mem_wdata,
    input  logic                    mem_ack,
    input  logic [7:0]              mem_rdata
);

    localparam int unsigned LineW = $clog2(NUM_LINES);
    localparam logic [OFFSET_WIDTH-1:0] LastBeat = OFFSET_WIDTH'(BLOCK_SIZE - 1);

    typedef enum logic [1:0] {StIdle, StFill, StWrite} state_e;

    state_e                  state_q, state_d;
    logic [LineW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [OFFSET_WIDTH-1:0] cnt_q, cnt_d;

    logic [OFFSET_WIDTH-1:0] start_off;
    logic [OFFSET_WIDTH-1:0] beat_off;
    logic [NUM_LINES-1:0]    victim_oh;
    logic                    any_hit;

`ifdef CACHE_CWF_EN
    assign start_off = cpu_addr[OFFSET_WIDTH-1:0];
`else
    assign start_off = '0;
`endif

    // Offset arithmetic is OFFSET_WIDTH wide, so the burst wraps within the block.
    assign beat_off  = start_off + cnt_q;
    assign victim_oh = {{(NUM_LINES-1){1'b0}}, 1'b1} << rr_ptr_q;
    assign any_hit   = |line_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (cpu_wr) begin
                    state_d = StWrite;
                end else if (cpu_rd && !any_hit) begin
                    state_d = StFill;
                    cnt_d   = '0;
                end
            end
            StFill: begin
                if (mem_ack) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastBeat) begin
                        state_d  = StIdle;
                        rr_ptr_d = rr_ptr_q + 1'b1;
                    end
                end
            end
            StWrite: begin
                if (mem_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cpu_rdy      = 1'b0;
        cpu_rdata    = '0;
        cache_wr     = 1'b0;
        fill_line_en = '0;
        fill_tag_en  = 1'b0;
        fill_en      = 1'b0;
        fill_off     = '0;
        fill_data    = '0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        unique case (state_q)
            StIdle: begin
                if (cpu_wr) begin
                    cache_wr = 1'b1;
                end else if (cpu_rd) begin
                    cpu_rdy = any_hit;
                    if (any_hit) begin
                        cpu_rdata = line_rdata;
                    end
                end else begin
                    cpu_rdy = 1'b1;
                end
            end
            StFill: begin
                mem_req  = 1'b1;
                mem_addr = {cpu_addr[ADDR_WIDTH-1:OFFSET_WIDTH], beat_off};
                if (mem_ack) begin
                    fill_en      = 1'b1;
                    fill_line_en = victim_oh;
                    fill_off     = beat_off;
                    fill_data    = mem_rdata;
                    // Tag/valid go in with the final byte so a partial line never hits.
                    fill_tag_en  = (cnt_q == LastBeat);
                end
            end
            StWrite: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                cpu_rdy   = mem_ack;
            end
            default: ;
        endcase
    end

    line_hit_onehot_a: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(line_hit));

    // The core must hold its request until the access completes.
    req_stable_a: assert property (@(posedge clk) disable iff (!rst_n)
        !cpu_rdy |=> ($stable(cpu_rd) && $stable(cpu_wr)));

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl with a behavioural 4-line cache array and a zero-wait memory
// whose read data is the low address byte.
module tb_cache_fill_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] cpu_addr;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_wdata;
    logic        cpu_rdy;
    logic [7:0]  cpu_rdata;
    logic [3:0]  line_hit;
    logic [7:0]  line_rdata;
    logic        cache_wr;
    logic [3:0]  fill_line_en;
    logic        fill_tag_en;
    logic        fill_en;
    logic [2:0]  fill_off;
    logic [7:0]  fill_data;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    logic        ack_en;
    int          n_total;
    int          n_bad;

    logic [12:0] tag_m [4];
    logic [3:0]  val_m;
    logic [7:0]  dat_m [4][8];

    cache_fill_ctrl #(
        .NUM_LINES  (4),
        .TAG_WIDTH  (13),
        .BLOCK_SIZE (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_addr     (cpu_addr),
        .cpu_rd       (cpu_rd),
        .cpu_wr       (cpu_wr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdy      (cpu_rdy),
        .cpu_rdata    (cpu_rdata),
        .line_hit     (line_hit),
        .line_rdata   (line_rdata),
        .cache_wr     (cache_wr),
        .fill_line_en (fill_line_en),
        .fill_tag_en  (fill_tag_en),
        .fill_en      (fill_en),
        .fill_off     (fill_off),
        .fill_data    (fill_data),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_ack   = mem_req && ack_en;
    assign mem_rdata = mem_ack ? mem_addr[7:0] : 8'h00;

    // Cache line array: tag compare, data mux, fill and invalidate.
    always_comb begin
        line_hit   = '0;
        line_rdata = '0;
        for (int i = 0; i < 4; i++) begin
            if (val_m[i] && tag_m[i] == cpu_addr[15:3]) begin
                line_hit[i] = 1'b1;
                line_rdata  = dat_m[i][cpu_addr[2:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_m <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (cache_wr && line_hit[i]) val_m[i] <= 1'b0;
                if (fill_en && fill_line_en[i]) begin
                    dat_m[i][fill_off] <= fill_data;
                    if (fill_tag_en) begin
                        tag_m[i] <= cpu_addr[15:3];
                        val_m[i] <= 1'b1;
                    end else begin
                        val_m[i] <= 1'b0;
                    end
                end
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that completes the read.
    task automatic do_read(input logic [15:0] addr, input bit miss, input int victim,
                           input logic [7:0] exp);
        logic [2:0] start;
        logic [2:0] beat;
        cpu_addr = addr;
        cpu_rd   = 1'b1;
        @(negedge clk);
        check_val("rd_rdy_first", 32'(cpu_rdy), 32'(!miss));
        check_val("rd_no_req", 32'(mem_req), 32'd0);
        if (miss) begin
            start = 3'd0;
`ifdef CACHE_CWF_EN
            start = addr[2:0];
`endif
            for (int b = 0; b < 8; b++) begin
                @(negedge clk);
                beat = start + 3'(b);
                check_val("fill_req", 32'({mem_req, mem_we}), 32'b10);
                check_val("fill_addr", 32'(mem_addr), 32'({addr[15:3], beat}));
                check_val("fill_en", 32'(fill_en), 32'd1);
                check_val("fill_off", 32'(fill_off), 32'(beat));
                check_val("fill_data", 32'(fill_data), 32'({addr[7:3], beat}));
                check_val("fill_line", 32'(fill_line_en), 32'd1 << victim);
                check_val("fill_tag", 32'(fill_tag_en), 32'(b == 7));
                check_val("fill_rdy", 32'(cpu_rdy), 32'd0);
            end
            @(negedge clk);
            check_val("replay_rdy", 32'(cpu_rdy), 32'd1);
            check_val("replay_no_req", 32'(mem_req), 32'd0);
        end
        check_val("rd_data", 32'(cpu_rdata), 32'(exp));
        @(posedge clk);
        #1;
        cpu_rd = 1'b0;
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [7:0] data);
        cpu_addr  = addr;
        cpu_wdata = data;
        cpu_wr    = 1'b1;
        @(negedge clk);
        check_val("wr_cache_wr", 32'(cache_wr), 32'd1);
        check_val("wr_rdy_idle", 32'(cpu_rdy), 32'd0);
        check_val("wr_req_idle", 32'(mem_req), 32'd0);
        @(negedge clk);
        check_val("wr_req", 32'({mem_req, mem_we}), 32'b11);
        check_val("wr_addr", 32'(mem_addr), 32'(addr));
        check_val("wr_data", 32'(mem_wdata), 32'(data));
        check_val("wr_rdy_ack", 32'(cpu_rdy), 32'd1);
        check_val("wr_cache_wr_off", 32'(cache_wr), 32'd0);
        @(posedge clk);
        #1;
        cpu_wr = 1'b0;
    endtask

    initial begin
        clk       = 1'b0;
        rst_n     = 1'b0;
        cpu_addr  = '0;
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        cpu_wdata = '0;
        ack_en    = 1'b1;
        n_total   = 0;
        n_bad     = 0;

        @(negedge clk);
        check_val("rst_rdy", 32'(cpu_rdy), 32'd1);
        check_val("rst_req", 32'(mem_req), 32'd0);
        check_val("rst_fill", 32'({fill_en, fill_tag_en, fill_line_en}), 32'd0);
        check_val("rst_cache_wr", 32'(cache_wr), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        do_read(16'h1234, 1'b1, 0, 8'h34);
        do_read(16'h1236, 1'b0, 0, 8'h36);
        do_write(16'h1236, 8'hAB);
        do_read(16'h1236, 1'b1, 1, 8'h36);
        do_read(16'h2005, 1'b1, 2, 8'h05);
        do_read(16'h3000, 1'b1, 3, 8'h00);
        do_read(16'h4000, 1'b1, 0, 8'h00);
        do_read(16'h5000, 1'b1, 1, 8'h00);
        do_read(16'h2007, 1'b0, 0, 8'h07);
        do_read(16'h1236, 1'b1, 2, 8'h36);

        // Three beats of a fill, a stalled memory, then reset in the middle of the burst.
        cpu_addr = 16'h6000;
        cpu_rd   = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        ack_en = 1'b0;
        @(negedge clk);
        check_val("stall_req", 32'(mem_req), 32'd1);
        check_val("stall_addr", 32'(mem_addr), 32'h6003);
        check_val("stall_fill_en", 32'(fill_en), 32'd0);
        @(negedge clk);
        check_val("stall_hold", 32'(mem_addr), 32'h6003);
        check_val("stall_rdy", 32'(cpu_rdy), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_req", 32'(mem_req), 32'd0);
        check_val("async_rst_rdy", 32'(cpu_rdy), 32'd0);
        cpu_rd = 1'b0;
        ack_en = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_read(16'h6000, 1'b1, 0, 8'h00);
        do_read(16'h6003, 1'b0, 0, 8'h03);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
